// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave backed by a 64-bit word SRAM with programmable read/write latency.
// Read and write paths are independent FSMs sharing one array.
module axi_lite_sram_slave #(
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int unsigned       RD_LAT = 2,
  parameter int unsigned       WR_LAT = 1
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [63:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [63:0]       WDATA,
  input  logic [7:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;

  typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WWait, WResp} w_state_e;

  logic [63:0] mem [DEPTH];

  // ---------------- read path ----------------
  r_state_e          r_state_q, r_state_d;
  logic [3:0]        rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [63:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              r_latch;
  logic [ADDR_W-1:0] r_lat_addr, rd_off, rd_word;
  logic              rd_in;
  logic [IdxW-1:0]   rd_idx;

  // With RD_LAT=0 the word is latched straight from ARADDR in the handshake cycle.
  assign r_lat_addr = (r_state_q == RIdle) ? ARADDR : raddr_q;
  assign rd_off     = r_lat_addr - BASE;
  assign rd_word    = rd_off >> 3;
  assign rd_in      = (r_lat_addr >= BASE) && (rd_word < ADDR_W'(DEPTH));
  assign rd_idx     = rd_word[IdxW-1:0];

  // Read FSM next-state.
  always_comb begin
    r_state_d = r_state_q;
    rcnt_d    = rcnt_q;
    raddr_d   = raddr_q;
    r_latch   = 1'b0;
    case (r_state_q)
      RIdle: begin
        if (ARVALID) begin
          raddr_d = ARADDR;
          if (RD_LAT == 0) begin
            r_latch   = 1'b1;
            r_state_d = RData;
          end else begin
            rcnt_d    = 4'(RD_LAT - 1);
            r_state_d = RWait;
          end
        end
      end
      RWait: begin
        if (rcnt_q == 4'd0) begin
          r_latch   = 1'b1;
          r_state_d = RData;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      RData: if (RREADY) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Read FSM state and response registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= RIdle;
      rcnt_q    <= 4'd0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      r_state_q <= r_state_d;
      rcnt_q    <= rcnt_d;
      raddr_q   <= raddr_d;
      if (r_latch) begin
        rdata_q <= rd_in ? mem[rd_idx] : 64'd0;
        rresp_q <= rd_in ? RespOkay : RespSlverr;
      end
    end
  end

  // ---------------- write path ----------------
  w_state_e          w_state_q, w_state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q;
  logic              commit, aw_hs, w_hs;
  logic [ADDR_W-1:0] aw_eff, wr_off, wr_word;
  logic [63:0]       wdata_eff;
  logic [7:0]        wstrb_eff;
  logic              wr_in;
  logic [IdxW-1:0]   wr_idx;

  assign aw_hs     = (w_state_q == WIdle) && !aw_have_q && AWVALID;
  assign w_hs      = (w_state_q == WIdle) && !w_have_q && WVALID;
  // Commit may happen in the capture cycle when WR_LAT=0, so take the live inputs then.
  assign aw_eff    = aw_have_q ? awaddr_q : AWADDR;
  assign wdata_eff = w_have_q ? wdata_q : WDATA;
  assign wstrb_eff = w_have_q ? wstrb_q : WSTRB;
  assign wr_off    = aw_eff - BASE;
  assign wr_word   = wr_off >> 3;
  assign wr_in     = (aw_eff >= BASE) && (wr_word < ADDR_W'(DEPTH));
  assign wr_idx    = wr_word[IdxW-1:0];

  // Write FSM next-state: gather AW and W in any order, wait, then commit.
  always_comb begin
    w_state_d = w_state_q;
    wcnt_d    = wcnt_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    commit    = 1'b0;
    case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_have_d = 1'b1;
          awaddr_d  = AWADDR;
        end
        if (w_hs) begin
          w_have_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        if ((aw_have_q || aw_hs) && (w_have_q || w_hs)) begin
          if (WR_LAT == 0) begin
            commit    = 1'b1;
            w_state_d = WResp;
          end else begin
            wcnt_d    = 4'(WR_LAT - 1);
            w_state_d = WWait;
          end
        end
      end
      WWait: begin
        if (wcnt_q == 4'd0) begin
          commit    = 1'b1;
          w_state_d = WResp;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      WResp: begin
        if (BREADY) begin
          w_state_d = WIdle;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Write FSM state and captured channel registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= WIdle;
      wcnt_q    <= 4'd0;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      wcnt_q    <= wcnt_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      if (commit) bresp_q <= wr_in ? RespOkay : RespSlverr;
    end
  end

  // Array update: byte merge under strobes; contents survive reset.
  always_ff @(posedge ACLK) begin
    if (!ARESET && commit && wr_in) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb_eff[b]) mem[wr_idx][8*b +: 8] <= wdata_eff[8*b +: 8];
      end
    end
  end

  // All outputs forced low while reset is asserted.
  assign ARREADY = !ARESET && (r_state_q == RIdle);
  assign RVALID  = !ARESET && (r_state_q == RData);
  assign RDATA   = ARESET ? 64'd0 : rdata_q;
  assign RRESP   = ARESET ? 2'b00 : rresp_q;
  assign AWREADY = !ARESET && (w_state_q == WIdle) && !aw_have_q;
  assign WREADY  = !ARESET && (w_state_q == WIdle) && !w_have_q;
  assign BVALID  = !ARESET && (w_state_q == WResp);
  assign BRESP   = ARESET ? 2'b00 : bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave (RD_LAT=2, WR_LAT=1, DEPTH=1024).
module tb_axi_lite_sram_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] ARADDR, AWADDR;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [63:0] RDATA, WDATA;
  logic [1:0]  RRESP, BRESP;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [7:0]  WSTRB;

  int checks = 0;
  int errors = 0;

  axi_lite_sram_slave #(
    .ADDR_W(32), .DEPTH(1024), .BASE(32'h8000_0000), .RD_LAT(2), .WR_LAT(1)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample/drive 1 time unit after it.
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [63:0] data,
                          output logic [1:0] resp, output int lat);
    int n = 0;
    ARADDR = addr; ARVALID = 1'b1;
    while (!ARREADY && n < 50) begin cyc(); n++; end
    cyc();
    ARVALID = 1'b0;
    lat = 1;
    while (!RVALID && lat < 50) begin cyc(); lat++; end
    if (!RVALID) check_eq("rd_timeout", 64'(RVALID), 64'd1);
    data = RDATA; resp = RRESP;
    RREADY = 1'b1;
    cyc();
    RREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, output logic [1:0] resp, output int lat);
    AWADDR = addr; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    cyc();
    AWVALID = 1'b0; WVALID = 1'b0;
    lat = 1;
    while (!BVALID && lat < 50) begin cyc(); lat++; end
    if (!BVALID) check_eq("wr_timeout", 64'(BVALID), 64'd1);
    resp = BRESP;
    BREADY = 1'b1;
    cyc();
    BREADY = 1'b0;
  endtask

  logic [63:0] d, keep;
  logic [1:0]  r;
  int          lat;

  initial begin
    ARESET = 1'b1; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    cyc(); cyc();
    check_eq("rst_arready", 64'(ARREADY), 64'd0);
    check_eq("rst_awready", 64'(AWREADY), 64'd0);
    check_eq("rst_rvalid", 64'(RVALID), 64'd0);
    check_eq("rst_bvalid", 64'(BVALID), 64'd0);
    check_eq("rst_rdata", RDATA, 64'd0);
    ARESET = 1'b0;
    #1;
    check_eq("idle_arready", 64'(ARREADY), 64'd1);
    check_eq("idle_awready", 64'(AWREADY), 64'd1);
    check_eq("idle_wready", 64'(WREADY), 64'd1);

    // Preload and single read.
    axi_write(32'h8000_0000, 64'h1122334455667788, 8'hFF, r, lat);
    check_eq("pre_bresp", 64'(r), 64'd0);
    check_eq("pre_blat", 64'(lat), 64'd2);
    axi_read(32'h8000_0000, d, r, lat);
    check_eq("rd0_lat", 64'(lat), 64'd3);
    check_eq("rd0_data", d, 64'h1122334455667788);
    check_eq("rd0_resp", 64'(r), 64'd0);

    // Partial write; addr[2:0] is ignored on the second access.
    axi_write(32'h8000_0008, 64'd0, 8'hFF, r, lat);
    axi_write(32'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, r, lat);
    check_eq("pw_bresp", 64'(r), 64'd0);
    check_eq("pw_blat", 64'(lat), 64'd2);
    axi_read(32'h8000_000D, d, r, lat);
    check_eq("pw_data", d, 64'h0000_0000_FFFF_FFFF);

    // WSTRB=0 changes nothing and answers OKAY.
    axi_write(32'h8000_0000, 64'hDEAD_BEEF_0000_0000, 8'h00, r, lat);
    check_eq("s0_bresp", 64'(r), 64'd0);
    axi_read(32'h8000_0000, d, r, lat);
    check_eq("s0_data", d, 64'h1122334455667788);

    // Out of range on both sides of the window.
    axi_write(32'h8000_1FF8, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, r, lat);
    axi_read(32'h7FFF_FFF8, d, r, lat);
    check_eq("oor_rresp", 64'(r), 64'd2);
    check_eq("oor_rdata", d, 64'd0);
    axi_write(32'h8000_2000, 64'h0123_4567_89AB_CDEF, 8'hFF, r, lat);
    check_eq("oor_bresp", 64'(r), 64'd2);
    axi_read(32'h8000_0000, d, r, lat);
    check_eq("oor_w0", d, 64'h1122334455667788);
    axi_read(32'h8000_0008, d, r, lat);
    check_eq("oor_w1", d, 64'h0000_0000_FFFF_FFFF);
    axi_read(32'h8000_1FF8, d, r, lat);
    check_eq("oor_wlast", d, 64'hA5A5_5A5A_0F0F_F0F0);
    check_eq("last_rresp", 64'(r), 64'd0);

    // W before AW.
    WDATA = 64'hCAFE_F00D_1234_5678; WSTRB = 8'hFF; WVALID = 1'b1;
    check_eq("wfirst_wready", 64'(WREADY), 64'd1);
    cyc();
    WVALID = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check_eq("wfirst_wready_lo", 64'(WREADY), 64'd0);
      check_eq("wfirst_bvalid_lo", 64'(BVALID), 64'd0);
      if (i < 3) cyc();
    end
    AWADDR = 32'h8000_0010; AWVALID = 1'b1;
    check_eq("wfirst_awready", 64'(AWREADY), 64'd1);
    cyc();
    AWVALID = 1'b0;
    lat = 1;
    while (!BVALID && lat < 50) begin cyc(); lat++; end
    check_eq("wfirst_blat", 64'(lat), 64'd2);
    check_eq("wfirst_bresp", 64'(BRESP), 64'd0);
    BREADY = 1'b1; cyc(); BREADY = 1'b0;
    axi_read(32'h8000_0010, d, r, lat);
    check_eq("wfirst_data", d, 64'hCAFE_F00D_1234_5678);

    // Read backpressure.
    ARADDR = 32'h8000_0000; ARVALID = 1'b1;
    cyc();
    ARVALID = 1'b0;
    lat = 1;
    while (!RVALID && lat < 50) begin cyc(); lat++; end
    keep = RDATA;
    check_eq("bp_data", keep, 64'h1122334455667788);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("bp_rvalid", 64'(RVALID), 64'd1);
      check_eq("bp_rdata_stable", RDATA, keep);
      check_eq("bp_arready", 64'(ARREADY), 64'd0);
    end
    RREADY = 1'b1;
    check_eq("bp_arready_hs", 64'(ARREADY), 64'd0);
    cyc();
    RREADY = 1'b0;
    check_eq("bp_arready_after", 64'(ARREADY), 64'd1);
    check_eq("bp_rvalid_after", 64'(RVALID), 64'd0);

    // Reset during R_WAIT abandons the read.
    ARADDR = 32'h8000_0008; ARVALID = 1'b1;
    cyc();
    ARVALID = 1'b0;
    ARESET = 1'b1;
    check_eq("mr_rvalid_rst", 64'(RVALID), 64'd0);
    cyc();
    ARESET = 1'b0;
    #1;
    check_eq("mr_arready", 64'(ARREADY), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("mr_rvalid_lo", 64'(RVALID), 64'd0);
      cyc();
    end
    axi_read(32'h8000_0008, d, r, lat);
    check_eq("mr_data", d, 64'h0000_0000_FFFF_FFFF);
    check_eq("mr_lat", 64'(lat), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
- AXI4-Lite slave that terminates the read and write channels issued by the core's data-memory master.
- Sits directly downstream of the memory-access stage's read and write masters.
- Backed by an internal word-organised SRAM array with programmable read and write latency, so the stage's stall logic can be exercised.
- Read and write paths are independent state machines sharing the array.

Parameters:
- ADDR_W, 32, address width.
- DEPTH, 1024, number of 64-bit words in the array.
- BASE, 32'h8000_0000, byte address of word 0.
- RD_LAT, 2, extra wait cycles between AR handshake and RVALID (0..15).
- WR_LAT, 1, extra wait cycles between write capture and BVALID (0..15).

Ports:
- ACLK  in  1  clock; all state changes on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- ARADDR  in  ADDR_W  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  64  read data.
- RRESP  out  2  read response: 00 OKAY, 10 SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- AWADDR  in  ADDR_W  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  64  write data.
- WSTRB  in  8  byte strobes; bit i enables WDATA[8i+7:8i].
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.

Behaviour:
- Reset: while ARESET=1 all outputs are 0. Both FSMs go to IDLE and counters clear. Array contents are not cleared.
- Reset mid-operation: the transaction is abandoned, RVALID/BVALID are 0 on the next edge, and any pending (not yet committed) write is dropped.
- Decode: index = (addr - BASE) >> 3; addr[2:0] is ignored.
  - In range means BASE <= addr < BASE + 8*DEPTH.
  - Out of range gives SLVERR; reads return RDATA=0 and writes modify nothing.
- Read FSM states:
  - R_IDLE: ARREADY=1. When ARVALID=1, capture the address and go to R_WAIT, counter = RD_LAT.
  - R_WAIT: decrement the counter. At 0, latch the array word (or 0) into RDATA, latch RRESP, and go to R_DATA.
  - R_DATA: RVALID=1, with RDATA/RRESP stable until RREADY=1. Then return to R_IDLE, so the next AR can be accepted the following cycle.
  - Latency: AR handshake in cycle T gives RVALID first high in cycle T+1+RD_LAT. With RD_LAT=0, R_WAIT lasts zero cycles.
- Write FSM states:
  - W_IDLE: AWREADY=1 until AW is captured; WREADY=1 until W is captured. AW and W may arrive in either order or in the same cycle, and each is held once captured.
  - When both are captured, go to W_WAIT, counter = WR_LAT.
  - W_WAIT: at counter 0, commit the write (per-byte merge under WSTRB, in-range only) and go to W_RESP with BVALID=1.
  - W_RESP: BRESP stable until BREADY=1, then return to W_IDLE. AWREADY/WREADY stay 0 from capture until the B handshake.
  - Latency: the later of the AW/W handshakes in cycle T gives BVALID first high in cycle T+1+WR_LAT. The array is updated at the same edge that raises BVALID.
- Boundary cases:
  - WSTRB=0: no bytes change and the response is OKAY.
  - Read and write to the same word: a read whose data latch coincides with the commit edge returns the old data. A read latching after that edge returns the new data.
  - Back-to-back transactions: at most one outstanding read and one outstanding write.
  - RREADY or BREADY held high early has no effect until the corresponding VALID is high.
- Counter width is 4 bits.

Test Plan:
- Reset then single read: RD_LAT=2, preload word 0 = 64'h1122334455667788, AR 0x80000000 at T -> ARREADY=1 at T, RVALID rises at T+3, RDATA=64'h1122334455667788, RRESP=00.
- Partial write then read: WR_LAT=1, AW and W same cycle T, addr 0x80000008, WDATA=64'hFFFF_FFFF_FFFF_FFFF, WSTRB=8'h0F, old word 0 -> BVALID at T+2, BRESP=00; read of 0x80000008 gives 64'h00000000FFFFFFFF.
- Out of range: read 0x7FFFFFF8 -> RRESP=10, RDATA=0. Write 0x80002000 (DEPTH=1024) -> BRESP=10, and the array is checksummed unchanged.
- W before AW: W at T, AW at T+3 -> WREADY=0 during T+1..T+3, BVALID at T+4+WR_LAT, data committed correctly.
- Backpressure: hold RREADY=0 for 5 cycles after RVALID -> RVALID/RDATA stable all 5 cycles, and ARREADY=0 until the cycle after the handshake.
- Reset mid-read: assert ARESET during R_WAIT -> RVALID stays 0, ARREADY=1 the cycle after release, and a new read returns correct data.
